// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle 32x32 multiply/divide controller that steps a
// shared external ALU one iteration per clock (shift-add multiply, restoring
// divide) and collects the 64-bit result into Hi/Lo.
// Optional signed support is compiled in with `define MULDIV_SIGNED_EN; without
// it Op[1] is ignored and every operation is unsigned.
module muldiv_sequencer #(
  parameter int BITS_SIZE = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [BITS_SIZE-1:0] OpA,
  input  logic [BITS_SIZE-1:0] OpB,
  output logic                 Busy,
  output logic                 Done,
  output logic [BITS_SIZE-1:0] Hi,
  output logic [BITS_SIZE-1:0] Lo,
  output logic                 DivByZero,
  output logic [3:0]           AluCtl,
  output logic [BITS_SIZE-1:0] AluA,
  output logic [BITS_SIZE-1:0] AluB,
  input  logic [BITS_SIZE-1:0] AluResult
);

  localparam int W = BITS_SIZE;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_RUN,
    S_POST,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  // hi: product high half / remainder; lo: multiplier / quotient
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  // b: multiplicand (multiply) or divisor (divide)
  logic [W-1:0]   b_q, b_d;
  logic           div_q, div_d;
  logic           sgn_q, sgn_d;
  logic           dbz_q, dbz_d;
  logic [W-1:0]   res_hi_q, res_lo_q;
  logic           res_dbz_q;

  logic [W-1:0]   sum;
  logic           carry;
  logic [W-1:0]   shf;
  logic           ge;
  logic           sgn_en;

`ifdef MULDIV_SIGNED_EN
  logic           sp_q, sp_d;
  logic           sr_q, sr_d;
  logic [W-1:0]   orig_q, orig_d;
  logic [2*W-1:0] prod_n;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
    return v[W-1] ? ('0 - v) : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return '0 - v;
  endfunction

  assign sgn_en = Op[1];
`else
  logic unused_op1;
  assign unused_op1 = Op[1];
  assign sgn_en     = 1'b0;
`endif

  assign Busy      = (state_q == S_PRE) || (state_q == S_RUN) || (state_q == S_POST);
  assign Done      = (state_q == S_DONE);
  assign Hi        = res_hi_q;
  assign Lo        = res_lo_q;
  assign DivByZero = res_dbz_q;

  // Next-state, datapath iteration and ALU drive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    dbz_d   = dbz_q;
`ifdef MULDIV_SIGNED_EN
    sp_d    = sp_q;
    sr_d    = sr_q;
    orig_d  = orig_q;
    prod_n  = neg_2w({hi_q, lo_q});
`endif
    AluCtl  = 4'd0;
    AluA    = '0;
    AluB    = '0;
    sum     = hi_q;
    carry   = 1'b0;
    shf     = {hi_q[W-2:0], lo_q[W-1]};
    ge      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (Start) begin
          div_d   = Op[0];
          sgn_d   = sgn_en;
          dbz_d   = Op[0] && (OpB == '0);
          hi_d    = '0;
          lo_d    = Op[0] ? OpA : OpB;
          b_d     = Op[0] ? OpB : OpA;
          cnt_d   = '0;
`ifdef MULDIV_SIGNED_EN
          orig_d  = OpA;
`endif
          state_d = sgn_en ? S_PRE : S_RUN;
        end
      end

      S_PRE: begin
`ifdef MULDIV_SIGNED_EN
        // Work on magnitudes; remember result signs for the fix-up in POST.
        sp_d = lo_q[W-1] ^ b_q[W-1];
        sr_d = div_q & lo_q[W-1];
        lo_d = abs_w(lo_q);
        b_d  = abs_w(b_q);
`endif
        state_d = S_RUN;
      end

      S_RUN: begin
        if (div_q) begin
          // Restoring step: the shifted remainder is 33 bits wide, its top
          // bit lives in hi_q[W-1] and forces a subtract when set.
          AluCtl = ALU_SUB;
          AluA   = shf;
          AluB   = b_q;
          ge     = hi_q[W-1] | (shf >= b_q);
          hi_d   = ge ? AluResult : shf;
          lo_d   = {lo_q[W-2:0], ge};
        end else begin
          // Shift-add step: carry out of the add is recovered by compare.
          AluCtl = ALU_ADD;
          AluA   = hi_q;
          AluB   = b_q;
          if (lo_q[0]) begin
            sum   = AluResult;
            carry = (AluResult < hi_q);
          end
          hi_d = {carry, sum[W-1:1]};
          lo_d = {sum[0], lo_q[W-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = sgn_q ? S_POST : S_DONE;
      end

      S_POST: begin
`ifdef MULDIV_SIGNED_EN
        if (div_q) begin
          lo_d = sp_q ? neg_w(lo_q) : lo_q;
          hi_d = sr_q ? neg_w(hi_q) : hi_q;
          if (dbz_q) begin
            lo_d = '1;
            hi_d = orig_q;
          end
        end else if (sp_q) begin
          {hi_d, lo_d} = prod_n;
        end
`endif
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state and visible results; results load on entry to DONE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      res_dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_d == S_DONE) begin
        res_hi_q  <= hi_d;
        res_lo_q  <= lo_d;
        res_dbz_q <= dbz_q;
      end
    end
  end

  // Working datapath registers; always reloaded on accept, so no reset.
  always_ff @(posedge Clk) begin
    hi_q  <= hi_d;
    lo_q  <= lo_d;
    b_q   <= b_d;
    div_q <= div_d;
    sgn_q <= sgn_d;
    dbz_q <= dbz_d;
`ifdef MULDIV_SIGNED_EN
    sp_q   <= sp_d;
    sr_q   <= sr_d;
    orig_q <= orig_d;
`endif
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer with a behavioural ALU.
module tb_muldiv_sequencer;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OpA, OpB;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;
  logic [3:0]  AluCtl;
  logic [31:0] AluA, AluB, AluResult;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          acc;
    logic [3:0]  ctl;
    bit          sgn;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   busy_n  = 0;
  int   ctl_bad = 0;

  muldiv_sequencer #(.BITS_SIZE(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero),
    .AluCtl(AluCtl), .AluA(AluA), .AluB(AluB), .AluResult(AluResult)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always_comb begin
    AluResult = '0;
    if (AluCtl == 4'd2)      AluResult = AluA + AluB;
    else if (AluCtl == 4'd6) AluResult = AluA - AluB;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0]        up;
    logic signed [63:0] sp;
    logic signed [31:0] sa, sbv;
    e.sgn = SIGNED_EN && op[1];
    e.lat = e.sgn ? 35 : 33;
    e.ctl = op[0] ? 4'd6 : 4'd2;
    e.acc = 0;
    e.dbz = 1'b0;
    sa  = a;
    sbv = b;
    if (!op[0]) begin
      if (e.sgn) begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        up = sp;
      end else begin
        up = {32'b0, a} * {32'b0, b};
      end
      e.hi = up[63:32];
      e.lo = up[31:0];
    end else if (b == 32'd0) begin
      e.dbz = 1'b1;
      e.lo  = 32'hFFFF_FFFF;
      e.hi  = a;
    end else if (e.sgn) begin
      e.lo = sa / sbv;
      e.hi = sa % sbv;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Call at a negedge; returns at the negedge after the sampling edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   idle;
    Start = 1'b1;
    Op    = op;
    OpA   = a;
    OpB   = b;
    idle  = !Busy;
    @(posedge Clk);
    #1;
    if (idle) begin
      e     = model(op, a, b);
      e.acc = cyc;
      sb.push_back(e);
    end
    Start = 1'b0;
    @(negedge Clk);
    if (idle) chk("busy_rise", Busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Done && n < 60);
    if (!Done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_busy"}, Busy, 0);
    chk({pfx, "_done"}, Done, 0);
    chk({pfx, "_hi"}, Hi, 0);
    chk({pfx, "_lo"}, Lo, 0);
    chk({pfx, "_dbz"}, DivByZero, 0);
    chk({pfx, "_aluctl"}, AluCtl, 0);
    chk({pfx, "_alua"}, AluA, 0);
    chk({pfx, "_alub"}, AluB, 0);
  endtask

  // Scoreboard: count busy cycles, watch ALU control, compare on Done.
  always @(negedge Clk) begin
    exp_t e;
    if (Busy) begin
      busy_n++;
      if (sb.size() > 0 && !sb[0].sgn && AluCtl !== sb[0].ctl) ctl_bad++;
    end
    if (Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("hi", Hi, e.hi);
        chk("lo", Lo, e.lo);
        chk("dbz", DivByZero, e.dbz);
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("busy_cycles", busy_n, e.lat - 1);
        if (!e.sgn) chk("alu_ctl_run", ctl_bad, 0);
      end
      busy_n  = 0;
      ctl_bad = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    Reset = 1'b1;
    Start = 1'b0;
    Op    = 2'b00;
    OpA   = '0;
    OpB   = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check_idle("reset");
    @(negedge Clk);

    // Unsigned multiply, largest operands
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    @(negedge Clk);

    // Unsigned divide, normal and divide-by-zero
    run_op(2'b01, 32'd100, 32'd7);
    wait_done();
    @(negedge Clk);
    run_op(2'b01, 32'h1234_5678, 32'd0);
    wait_done();
    @(negedge Clk);

    // Signed-request multiply and divide
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5);
    wait_done();
    @(negedge Clk);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    @(negedge Clk);

    // Random mix of operations
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      run_op(rop, ra, rb);
      wait_done();
      @(negedge Clk);
    end

    // Start while busy is ignored
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge Clk);
    run_op(2'b01, 32'h0000_DEAD, 32'd5);
    wait_done();
    @(negedge Clk);

    // Back-to-back: Start in the DONE cycle
    run_op(2'b00, 32'd123_456, 32'd789);
    wait_done();
    run_op(2'b01, 32'hCAFE_F00D, 32'd17);
    wait_done();
    @(negedge Clk);

    // Reset in the middle of an operation, then a fresh divide
    run_op(2'b01, 32'd1000, 32'd3);
    repeat (13) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    sb.delete();
    busy_n  = 0;
    ctl_bad = 0;
    check_idle("midrst");
    @(negedge Clk);
    run_op(2'b01, 32'd9, 32'd3);
    wait_done();
    repeat (2) @(negedge Clk);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller that runs 32×32 multiply and divide on the shared 32-bit ALU. It steps the ALU one iteration per clock: ADD for shift-add multiply, SUB for restoring divide. The 64-bit result is collected into HI/LO registers. It sits beside the execute stage, drives the ALU's control and operand inputs while busy, and gives the pipeline a start/busy/done handshake.

## Interface
- BITS_SIZE, 32, operand/ALU width; only 32 is supported.
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- Op  input  2  bit0: 0=multiply, 1=divide; bit1: 1=signed (see Configuration).
- OpA  input  32  multiplicand / dividend, sampled with Start.
- OpB  input  32  multiplier / divisor, sampled with Start.
- Busy  output  1  high from the accept edge until Done.
- Done  output  1  one-cycle pulse; Hi/Lo/DivByZero are valid from this cycle on.
- Hi  output  32  product[63:32] or remainder.
- Lo  output  32  product[31:0] or quotient.
- DivByZero  output  1  divide with OpB==0; held with the result.
- AluCtl  output  4  to the ALU: 2=ADD, 6=SUB, 0 when idle.
- AluA, AluB  output  32 each  ALU operands; 0 when idle.
- AluResult  input  32  combinational ALU result, used in the same cycle.

## Operation
- States: IDLE, PRE (signed only), RUN, POST (signed only), DONE.
- IDLE/DONE with Start=1: latch OpA, OpB, Op; clear the iteration counter to 0; go to RUN, or to PRE if signed is enabled.
- Start when Busy=1 is ignored; operands are not resampled.
- Multiply, RUN, 32 iterations:
  - Registers are the 64-bit {P_hi, P_lo}, with P_lo initialised to the multiplier and P_hi to 0.
  - ALU outputs: AluCtl=2, AluA=P_hi, AluB=multiplicand.
  - If P_lo[0]=1: sum=AluResult and carry=(AluResult < AluA), an unsigned compare done locally. Otherwise sum=P_hi and carry=0.
  - Update: {P_hi,P_lo} <= {carry, sum, P_lo[31:1]}.
- Divide, RUN, 32 iterations (restoring):
  - Registers: remainder R initialised to 0, quotient register Q initialised to the dividend.
  - Shifted remainder S={R[30:0],Q[31]}, with top bit t=R[31].
  - ALU outputs: AluCtl=6, AluA=S, AluB=divisor.
  - ge = t | (S >= divisor).
  - Update: R <= ge ? AluResult : S; Q <= {Q[30:0], ge}.
- Divisor 0 needs no special path: the result is Lo=0xFFFFFFFF and Hi=dividend, and DivByZero=1.
- RUN exits after iteration 31 (counter wraps 31→0) to DONE, or to POST if signed.
- DONE: Busy=0, Done=1, Hi/Lo load. Next cycle goes to IDLE unless Start is accepted.
- Hi, Lo and DivByZero hold until the next Done or Reset.
- Reset, any state: state=IDLE; Busy=0, Done=0, Hi=0, Lo=0, DivByZero=0; AluCtl=0, AluA=0, AluB=0. An in-flight operation is discarded.

## Timing
- Start accepted at edge k: Busy=1 during cycles k+1…k+32, and Done=1 in cycle k+33 (unsigned latency 33).
- Signed latency is 35: PRE and POST add one cycle each.
- Back-to-back: Start in the DONE cycle is accepted, so Busy rises the next cycle.
- AluCtl/AluA/AluB are combinational from registered state. AluResult must settle within the same cycle.

## Configuration
- MULDIV_SIGNED_EN defined:
  - Op[1]=1 enables PRE and POST.
  - PRE: replace operands with their absolute values; record sign_p=a^b and sign_r=a.
  - POST: multiply negates the 64-bit product if sign_p. Divide negates Q if sign_p and R if sign_r.
  - Negation uses a local two's complement, not the ALU.
  - Signed divide by 0 forces Lo=0xFFFFFFFF and Hi=original dividend.
- Not defined: Op[1] is ignored, every operation is unsigned, and PRE/POST are never entered.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → Done at k+33; Hi=0xFFFFFFFE, Lo=0x00000001; AluCtl=2 throughout RUN.
- DIVU 100/7 → Lo=14, Hi=2, DivByZero=0. DIVU 0x12345678/0 → Lo=0xFFFFFFFF, Hi=0x12345678, DivByZero=1.
- Signed multiply -3×5:
  - With MULDIV_SIGNED_EN: Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, Done at k+35.
  - Without it: Hi=0x00000004, Lo=0xFFFFFFF1, Done at k+33.
- Signed divide -7/2 with MULDIV_SIGNED_EN → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- Start pulsed with new operands at k+10 during a MULTU → ignored; the original result is unchanged. Start held in the DONE cycle → second operation starts, with Done 33 cycles later.
- Reset asserted at k+15 → next cycle all outputs are 0 and state is IDLE; a subsequent DIVU 9/3 gives Lo=3, Hi=0.
